gen_class_ctrl: RTL and testbench

GEN_CLASS_CTRL -- requirements
Module: gen_class_ctrl

---
 rtl/gen_class_ctrl_pkg.sv | 25 ++
 rtl/gen_class_ctrl_stats.sv | 49 ++++
 rtl/gen_class_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_gen_class_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_class_ctrl_pkg.sv
// gen_class_ctrl_pkg
// Shared types and encodings for the HDC train/infer sequencing controller.
//   state_t      : controller FSM states
//   MODE_TRAIN/MODE_INFER : job mode encodings (start-time mode input)
//   OP_TRAIN/OP_INFER     : classifier op encodings (cls_op output)
package gen_class_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_T_ACCEPT  = 3'd1,
      ST_T_UPDATE  = 3'd2,
      ST_I_ACCEPT  = 3'd3,
      ST_I_EVAL    = 3'd4,
      ST_I_CAPTURE = 3'd5,
      ST_I_RESULT  = 3'd6,
      ST_DONE      = 3'd7
   } state_t;

   localparam logic MODE_TRAIN = 1'b0;
   localparam logic MODE_INFER = 1'b1;

   localparam logic OP_TRAIN = 1'b0;
   localparam logic OP_INFER = 1'b1;

endpackage

// File: rtl/gen_class_ctrl_stats.sv
// gen_class_ctrl_stats
// Saturating per-label result counters for accepted inference results.
// Only instantiated when GEN_CLASS_CTRL_STATS_EN is defined.
// Ports:
//   clk, nrst          : clock, synchronous active-low reset
//   i_clear            : clear both counters (accepted job start)
//   i_inc              : one inference result accepted this cycle
//   i_label            : label of that result (1 = seizure)
//   o_stat_seizure     : count of seizure results
//   o_stat_nonseizure  : count of non-seizure results
module gen_class_ctrl_stats
   import gen_class_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_clear,
   input  logic             i_inc,
   input  logic             i_label,
   output logic [CNT_W-1:0] o_stat_seizure,
   output logic [CNT_W-1:0] o_stat_nonseizure
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_seizure;
   logic [CNT_W-1:0] r_nonseizure;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_seizure    <= '0;
         r_nonseizure <= '0;
      end else if (i_clear) begin
         r_seizure    <= '0;
         r_nonseizure <= '0;
      end else if (i_inc) begin
         if (i_label) begin
            if (r_seizure != '1) r_seizure <= r_seizure + CNT_ONE;
         end else begin
            if (r_nonseizure != '1) r_nonseizure <= r_nonseizure + CNT_ONE;
         end
      end
   end

   assign o_stat_seizure    = r_seizure;
   assign o_stat_nonseizure = r_nonseizure;

endmodule

// File: rtl/gen_class_ctrl.sv
// gen_class_ctrl
// Sequences train and infer jobs between a sample stream, an HDC classifier
// memory and a result stream.
// Optional feature macro: GEN_CLASS_CTRL_STATS_EN (adds stat_seizure and
// stat_nonseizure saturating result counters).
// Ports:
//   clk, nrst                  : clock, synchronous active-low reset
//   start, mode, num_samples   : job launch (sampled on accepted start)
//   abort                      : cancel current job
//   s_valid/s_ready/s_hv/s_label : sample input stream
//   cls_op, cls_trained_label, cls_hv : classifier controls
//   cls_predicted_label        : registered classifier prediction
//   res_valid/res_ready/res_label/res_index : result stream
//   busy, done                 : job status
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_T_ACCEPT  | train: waiting for a sample
// ST_T_UPDATE  | train: one-cycle classifier memory update (cls_op=0)
// ST_I_ACCEPT  | infer: waiting for a sample
// ST_I_EVAL    | infer: classifier registers its prediction
// ST_I_CAPTURE | infer: latch prediction and index
// ST_I_RESULT  | infer: result presented until res_ready
// ST_DONE      | one-cycle done pulse
module gen_class_ctrl
   import gen_class_ctrl_pkg::*;
#(
   parameter int DIMENSIONS = 10000,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [CNT_W-1:0]      num_samples,
   input  logic                  abort,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DIMENSIONS-1:0] s_hv,
   input  logic                  s_label,
   output logic                  cls_op,
   output logic                  cls_trained_label,
   output logic [DIMENSIONS-1:0] cls_hv,
   input  logic                  cls_predicted_label,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_label,
   output logic [CNT_W-1:0]      res_index,
   output logic                  busy,
   output logic                  done
`ifdef GEN_CLASS_CTRL_STATS_EN
   ,
   output logic [CNT_W-1:0]      stat_seizure,
   output logic [CNT_W-1:0]      stat_nonseizure
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      r_num;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic [DIMENSIONS-1:0] r_cls_hv;
   logic                  r_trained_label;
   logic                  r_res_label;
   logic [CNT_W-1:0]      r_res_index;
   logic                  w_s_ready;
   logic                  w_cls_op;
   logic                  w_res_valid;
   logic                  w_done;
   logic                  w_hs;
   logic                  w_accept_start;

   assign w_cnt_inc      = r_cnt + CNT_ONE;
   assign w_hs           = s_valid & w_s_ready;
   assign w_accept_start = (r_state == ST_IDLE) & start;

   always_comb begin
      w_next      = r_state;
      w_s_ready   = 1'b0;
      w_cls_op    = OP_INFER;
      w_res_valid = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (num_samples == '0)       w_next = ST_DONE;
               else if (mode == MODE_TRAIN) w_next = ST_T_ACCEPT;
               else                         w_next = ST_I_ACCEPT;
            end
         end
         ST_T_ACCEPT: begin
            w_s_ready = 1'b1;
            if (w_hs) w_next = ST_T_UPDATE;
         end
         ST_T_UPDATE: begin
            w_cls_op = OP_TRAIN;
            w_next   = (w_cnt_inc == r_num) ? ST_DONE : ST_T_ACCEPT;
         end
         ST_I_ACCEPT: begin
            w_s_ready = 1'b1;
            if (w_hs) w_next = ST_I_EVAL;
         end
         ST_I_EVAL:    w_next = ST_I_CAPTURE;
         ST_I_CAPTURE: w_next = ST_I_RESULT;
         ST_I_RESULT: begin
            w_res_valid = 1'b1;
            if (res_ready) w_next = (w_cnt_inc == r_num) ? ST_DONE : ST_I_ACCEPT;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      // Abort wins over every transition; an in-flight T_UPDATE cycle still
      // drives cls_op=0 because cls_op above is decoded from the current state.
      if (abort && (r_state != ST_IDLE)) begin
         w_next = ST_IDLE;
         w_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         r_num           <= '0;
         r_cls_hv        <= '0;
         r_trained_label <= 1'b0;
         r_res_label     <= 1'b0;
         r_res_index     <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept_start) begin
            r_cnt <= '0;
            r_num <= num_samples;
         end else if ((r_state == ST_T_UPDATE) ||
                      ((r_state == ST_I_RESULT) && res_ready)) begin
            r_cnt <= w_cnt_inc;
         end
         if (w_hs) begin
            r_cls_hv <= s_hv;
            if (r_state == ST_T_ACCEPT) r_trained_label <= s_label;
         end
         if ((r_state == ST_I_CAPTURE) && !abort) begin
            r_res_label <= cls_predicted_label;
            r_res_index <= r_cnt;
         end
      end
   end

   assign s_ready           = w_s_ready;
   assign cls_op            = w_cls_op;
   assign cls_trained_label = r_trained_label;
   assign cls_hv            = r_cls_hv;
   assign res_valid         = w_res_valid;
   assign res_label         = r_res_label;
   assign res_index         = r_res_index;
   assign busy              = (r_state != ST_IDLE);
   assign done              = w_done;

`ifdef GEN_CLASS_CTRL_STATS_EN
   logic w_res_accept;
   assign w_res_accept = w_res_valid & res_ready & ~abort;

   gen_class_ctrl_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .clk               (clk),
      .nrst              (nrst),
      .i_clear           (w_accept_start),
      .i_inc             (w_res_accept),
      .i_label           (r_res_label),
      .o_stat_seizure    (stat_seizure),
      .o_stat_nonseizure (stat_nonseizure)
   );
`endif

endmodule

// File: tb/tb_gen_class_ctrl.sv
// Testbench for gen_class_ctrl: job-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_gen_class_ctrl;

   localparam int DW = 64;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [CW-1:0] num = '0;
   logic          abort = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_hv = '0;
   logic          s_label = 1'b0;
   logic          cls_op;
   logic          cls_trained_label;
   logic [DW-1:0] cls_hv;
   logic          cls_pred = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          res_label;
   logic [CW-1:0] res_index;
   logic          busy;
   logic          done;
`ifdef GEN_CLASS_CTRL_STATS_EN
   logic [CW-1:0] stat_seizure;
   logic [CW-1:0] stat_nonseizure;
`endif

   gen_class_ctrl #(.DIMENSIONS(DW), .CNT_W(CW)) dut (
      .clk                 (clk),
      .nrst                (nrst),
      .start               (start),
      .mode                (mode),
      .num_samples         (num),
      .abort               (abort),
      .s_valid             (s_valid),
      .s_ready             (s_ready),
      .s_hv                (s_hv),
      .s_label             (s_label),
      .cls_op              (cls_op),
      .cls_trained_label   (cls_trained_label),
      .cls_hv              (cls_hv),
      .cls_predicted_label (cls_pred),
      .res_valid           (res_valid),
      .res_ready           (res_ready),
      .res_label           (res_label),
      .res_index           (res_index),
      .busy                (busy),
      .done                (done)
`ifdef GEN_CLASS_CTRL_STATS_EN
      ,
      .stat_seizure        (stat_seizure),
      .stat_nonseizure     (stat_nonseizure)
`endif
   );

   always #5 clk = ~clk;

   // Classifier stand-in: registered prediction = parity of presented hv.
   always @(posedge clk) cls_pred <= ^cls_hv;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Event records for directed checks.
   int q_oplow[$];
   int q_done[$];
   int q_hs[$];
   int q_racc[$];
   int q_rlab[$];
   int q_ridx[$];
   int n_rv = 0;
   logic [DW-1:0] feed_q[$];
   bit hs_flag = 0;

   task automatic clear_rec();
      q_oplow.delete(); q_done.delete(); q_hs.delete();
      q_racc.delete(); q_rlab.delete(); q_ridx.delete();
      n_rv = 0;
   endtask

   // Job-level model: m_since = -1 waiting for a sample, otherwise cycles
   // elapsed since the sample handshake.
   bit            m_valid = 0;
   bit            m_act = 0, m_done = 0, m_mode = 0;
   int            m_num = 0, m_idx = 0, m_since = -1;
   logic [DW-1:0] m_hv = '0;
   logic          m_lab = 1'b0, m_rlab = 1'b0;
   int            m_ridx = 0, m_seiz = 0, m_non = 0;

   initial forever begin
      bit e_busy, e_done, e_sready, e_op, e_rv, hs;
      @(negedge clk);
      e_busy   = m_act | m_done;
      e_done   = m_done & ~abort;
      e_sready = m_act && (m_since < 0);
      e_op     = !(m_act && (m_mode == 1'b0) && (m_since == 1));
      e_rv     = m_act && (m_mode == 1'b1) && (m_since >= 3);
      if (m_valid) begin
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("s_ready", s_ready, e_sready);
         chk("cls_op", cls_op, e_op);
         chk("res_valid", res_valid, e_rv);
         chk("res_label", res_label, m_rlab);
         chk("res_index", res_index, m_ridx);
         chk("cls_hv", cls_hv, m_hv);
         chk("cls_trained_label", cls_trained_label, m_lab);
`ifdef GEN_CLASS_CTRL_STATS_EN
         chk("stat_seizure", stat_seizure, m_seiz);
         chk("stat_nonseizure", stat_nonseizure, m_non);
`endif
      end
      if (cls_op === 1'b0) q_oplow.push_back(cyc);
      if (done === 1'b1) q_done.push_back(cyc);
      if (res_valid === 1'b1) n_rv++;
      if ((res_valid === 1'b1) && (res_ready === 1'b1)) begin
         q_racc.push_back(cyc); q_rlab.push_back(int'(res_label)); q_ridx.push_back(int'(res_index));
      end
      hs = e_sready & s_valid;
      if (hs) begin q_hs.push_back(cyc); hs_flag = 1; end
      if (!nrst) begin
         m_valid = 1; m_act = 0; m_done = 0; m_since = -1; m_idx = 0; m_num = 0;
         m_hv = '0; m_lab = 1'b0; m_rlab = 1'b0; m_ridx = 0; m_seiz = 0; m_non = 0;
      end else begin
         if (hs) begin
            m_hv = s_hv;
            if (m_mode == 1'b0) m_lab = s_label;
         end
         if (m_done) m_done = 0;
         else if (!m_act) begin
            if (start) begin
               m_seiz = 0; m_non = 0;
               if (num == 0) m_done = 1;
               else begin
                  m_act = 1; m_mode = mode; m_num = int'(num); m_idx = 0; m_since = -1;
               end
            end
         end else if (abort) m_act = 0;
         else if (m_since < 0) begin
            if (hs) m_since = 1;
         end else if (m_mode == 1'b0) begin
            m_idx++;
            if (m_idx == m_num) begin m_act = 0; m_done = 1; end
            else m_since = -1;
         end else if (m_since == 1) m_since = 2;
         else if (m_since == 2) begin
            m_rlab = ^m_hv; m_ridx = m_idx; m_since = 3;
         end else if (res_ready) begin
            if (m_rlab) begin if (m_seiz < CMAX) m_seiz++; end
            else begin if (m_non < CMAX) m_non++; end
            m_idx++;
            if (m_idx == m_num) begin m_act = 0; m_done = 1; end
            else m_since = -1;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      if (hs_flag) begin
         hs_flag = 0;
         if (feed_q.size() > 0) s_hv = feed_q.pop_front();
      end
   endtask

   task automatic launch(input logic md, input int n);
      mode = md; num = CW'(n); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int p;
      bit ok;
      logic [DW-1:0] hv;

      nrst = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_cls_op", cls_op, 1);
      chk("rst_cls_hv", cls_hv, 0);
      nrst = 1'b1;
      tick();

      // Train: 3 samples, s_valid held high.
      clear_rec();
      s_valid = 1'b1; s_label = 1'b1; s_hv = {$urandom, $urandom};
      p = cyc;
      launch(1'b0, 3);
      repeat (12) tick();
      s_valid = 1'b0;
      chk("train_oplow_count", q_oplow.size(), 3);
      if (q_oplow.size() >= 3) begin
         chk("train_first_update", q_oplow[0] - p, 2);
         chk("train_gap1", q_oplow[1] - q_oplow[0], 2);
         chk("train_gap2", q_oplow[2] - q_oplow[1], 2);
         if (q_done.size() >= 1) chk("train_done_after_update", q_done[0] - q_oplow[2], 1);
      end
      chk("train_done_count", q_done.size(), 1);
      chk("train_no_res_valid", n_rv, 0);
      chk("train_label", cls_trained_label, 1);

      // Infer: 2 samples, predictions 1 then 0.
      clear_rec();
      s_hv = 64'h1; feed_q.push_back(64'h3);
      s_valid = 1'b1; res_ready = 1'b1;
      launch(1'b1, 2);
      repeat (14) tick();
      s_valid = 1'b0;
      chk("infer_result_count", q_racc.size(), 2);
      if ((q_racc.size() >= 2) && (q_hs.size() >= 2)) begin
         chk("infer_latency0", q_racc[0] - q_hs[0], 3);
         chk("infer_latency1", q_racc[1] - q_hs[1], 3);
         chk("infer_label0", q_rlab[0], 1);
         chk("infer_label1", q_rlab[1], 0);
         chk("infer_index0", q_ridx[0], 0);
         chk("infer_index1", q_ridx[1], 1);
      end
      chk("infer_no_oplow", q_oplow.size(), 0);

      // Backpressure: res_ready low 5 cycles in I_RESULT.
      res_ready = 1'b0;
      hv = 64'h7; s_hv = hv; s_valid = 1'b1;
      launch(1'b1, 1);
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (res_valid === 1'b1) ok = 1;
         else tick();
      end
      chk("bp_wait_res_valid", ok, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_label", res_label, ^hv);
         chk("bp_res_index", res_index, 0);
         chk("bp_s_ready", s_ready, 0);
         tick();
      end
      res_ready = 1'b1;
      tick();
      chk("bp_done", done, 1);
      s_valid = 1'b0;
      tick();

      // Zero-length job, then start during busy is ignored.
      launch(1'b0, 0);
      chk("zero_done", done, 1);
      tick();
      chk("zero_idle", busy, 0);
      launch(1'b0, 2);
      tick();
      launch(1'b1, 5);
      clear_rec();
      s_valid = 1'b1; s_hv = {$urandom, $urandom};
      repeat (8) tick();
      s_valid = 1'b0;
      chk("busy_start_updates", q_oplow.size(), 2);
      chk("busy_start_no_rv", n_rv, 0);
      chk("busy_start_done", q_done.size(), 1);

      // Abort in I_EVAL.
      s_valid = 1'b1; s_hv = {$urandom, $urandom}; res_ready = 1'b1;
      launch(1'b1, 3);
      tick();
      s_valid = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", busy, 0);
      clear_rec();
      repeat (5) tick();
      chk("abort_no_rv", n_rv, 0);

      // Reset during T_ACCEPT.
      launch(1'b0, 4);
      tick();
      nrst = 1'b0;
      tick();
      chk("rst2_busy", busy, 0);
      chk("rst2_cls_op", cls_op, 1);
      chk("rst2_s_ready", s_ready, 0);
      chk("rst2_res_valid", res_valid, 0);
      chk("rst2_done", done, 0);
      chk("rst2_cls_hv", cls_hv, 0);
      chk("rst2_trained_label", cls_trained_label, 0);
      chk("rst2_res_label", res_label, 0);
      chk("rst2_res_index", res_index, 0);
      nrst = 1'b1;
      tick();

      // Maximum count without wrap.
      clear_rec();
      s_valid = 1'b1;
      launch(1'b0, CMAX);
      repeat (40) tick();
      chk("max_train_updates", q_oplow.size(), CMAX);
      chk("max_train_done", q_done.size(), 1);
      clear_rec();
      launch(1'b1, CMAX);
      repeat (70) tick();
      chk("max_infer_results", q_racc.size(), CMAX);
      if (q_ridx.size() == CMAX) chk("max_infer_last_index", q_ridx[CMAX-1], CMAX - 1);
      chk("max_infer_done", q_done.size(), 1);
      s_valid = 1'b0;

`ifdef GEN_CLASS_CTRL_STATS_EN
      s_hv = 64'h1;
      feed_q.push_back(64'h7); feed_q.push_back(64'h3); feed_q.push_back(64'h1);
      s_valid = 1'b1; res_ready = 1'b1;
      launch(1'b1, 4);
      repeat (25) tick();
      s_valid = 1'b0;
      chk("stats_seizure", stat_seizure, 3);
      chk("stats_nonseizure", stat_nonseizure, 1);
`endif
      feed_q.delete();

      // Randomized traffic against the model.
      for (int k = 0; k < 4000; k++) begin
         s_valid   = ($urandom_range(0, 3) != 0);
         s_label   = 1'($urandom_range(0, 1));
         s_hv      = {$urandom, $urandom};
         res_ready = ($urandom_range(0, 2) != 0);
         abort     = ($urandom_range(0, 60) == 0);
         start     = ($urandom_range(0, 7) == 0);
         mode      = 1'($urandom_range(0, 1));
         num       = ($urandom_range(0, 9) == 0) ? CW'(CMAX) : CW'($urandom_range(0, 6));
         nrst      = ($urandom_range(0, 500) != 0);
         tick();
      end
      nrst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
